// File: rtl/sobel_window_ctrl.sv
// Step/write sequencer for a 3x3 Sobel window: drives line-buffer shifts,
// input pops, zero-padded flush and raster-ordered output writes per frame.
module sobel_window_ctrl #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_empty,
    output logic        in_rd_en,
    output logic        shift_en,
    output logic        pad_zero,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [15:0] out_row,
    output logic [15:0] out_col,
    output logic        border,
    output logic        busy,
    output logic        frame_done
);

    // state | meaning
    // IDLE  | waiting for the first pixel of a frame
    // FILL  | priming line buffers, steps 0..WIDTH, no writes
    // RUN   | steady state, pop one pixel and write one result per step
    // FLUSH | shift zeros to drain the last WIDTH+1 results
    // DONE  | one-cycle frame_done, counters cleared

    localparam int LAST_STEP = WIDTH * HEIGHT + WIDTH;
    localparam int CW        = $clog2(LAST_STEP + 1);

    localparam logic [CW-1:0] S_FILL_END = CW'(WIDTH);
    localparam logic [CW-1:0] S_RUN_END  = CW'(WIDTH * HEIGHT - 1);
    localparam logic [CW-1:0] S_LAST     = CW'(LAST_STEP);
    localparam logic [15:0]   COL_MAX    = 16'(WIDTH - 1);
    localparam logic [15:0]   ROW_MAX    = 16'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] s_cnt;
    logic [15:0]   row_cnt;
    logic [15:0]   col_cnt;

    // Outputs are gated by reset so nothing fires in the reset cycle itself.
    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        pad_zero   = 1'b0;
        frame_done = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!in_empty) state_nxt = FILL;
                end
                FILL: begin
                    shift_en = !in_empty;
                    if (shift_en && s_cnt == S_FILL_END) state_nxt = RUN;
                end
                RUN: begin
                    shift_en = !in_empty && !out_full;
                    if (shift_en && s_cnt == S_RUN_END) state_nxt = FLUSH;
                end
                FLUSH: begin
                    pad_zero = 1'b1;
                    shift_en = !out_full;
                    if (shift_en && s_cnt == S_LAST) state_nxt = DONE;
                end
                DONE: begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign in_rd_en  = shift_en && (state == FILL || state == RUN);
    assign out_wr_en = shift_en && (s_cnt > S_FILL_END);
    assign out_row   = row_cnt;
    assign out_col   = col_cnt;
    assign border    = out_wr_en && (row_cnt == 16'd0 || row_cnt == ROW_MAX ||
                                     col_cnt == 16'd0 || col_cnt == COL_MAX);
    assign busy      = !reset && (state != IDLE);

    // row/col always point at the next pixel to be written.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            s_cnt   <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == DONE) begin
                s_cnt   <= '0;
                row_cnt <= '0;
                col_cnt <= '0;
            end else begin
                if (shift_en) s_cnt <= s_cnt + CW'(1);
                if (out_wr_en) begin
                    if (col_cnt == COL_MAX) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 16'd1;
                    end else begin
                        col_cnt <= col_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule
